// File: rtl/opamp_trim_sequencer_if.sv
// Bus bundle for opamp_trim_sequencer: serial trim loading, scanner control
// and the switch/trim outputs toward the op-amp macro.
interface opamp_trim_sequencer_if #(
  parameter int CHANNELS = 4,
  parameter int TRIM_W   = 5,
  parameter int DWELL_W  = 8
);
  localparam int AW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic                ena;
  logic                ser_valid;
  logic                ser_data;
  logic                ser_clr;
  logic                run;
  logic [DWELL_W-1:0]  dwell;
  logic [CHANNELS-1:0] sel;
  logic [AW-1:0]       ch_idx;
  logic [TRIM_W-1:0]   trim_out;
  logic                sample;
  logic                chop;
  logic                busy;

  modport master (
    output ena, ser_valid, ser_data, ser_clr, run, dwell,
    input  sel, ch_idx, trim_out, sample, chop, busy
  );

  modport slave (
    input  ena, ser_valid, ser_data, ser_clr, run, dwell,
    output sel, ch_idx, trim_out, sample, chop, busy
  );
endinterface

// File: rtl/opamp_trim_sequencer.sv
// Offset-trim store plus round-robin break-before-make channel scanner for the
// multi-channel op-amp macro. Trim codes arrive as serial frames (address bits
// then data bits, MSB first); the scanner alternates DEAD (all switches off)
// and DWELL (one switch on) phases, pulsing sample on the last DWELL cycle.
// Optional feature macro: OPAMP_CHOP_EN -- two DWELL phases per channel with
// chop=0 then chop=1; when undefined chop stays 0.
module opamp_trim_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int TRIM_W      = 5,
  parameter int DWELL_W     = 8,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  opamp_trim_sequencer_if.slave bus
);
  localparam int AW      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam int FRAME_W = AW + TRIM_W;
  localparam int BC_W    = $clog2(FRAME_W + 1);
  localparam int DC_W    = $clog2(DEAD_CYCLES + 1);
  localparam int CNT_W   = (DWELL_W > DC_W) ? DWELL_W : DC_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DEAD  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(FRAME_W - 1);
  localparam logic [AW-1:0]    CH_LAST   = AW'(CHANNELS - 1);

  // serial loader
  logic [TRIM_W-1:0]  r_trim [CHANNELS];
  logic [FRAME_W-2:0] r_shift;
  logic [BC_W-1:0]    r_bit_cnt;
  logic [FRAME_W-1:0] w_frame;
  logic [AW-1:0]      w_addr;
  logic [TRIM_W-1:0]  w_data;
  logic               w_addr_ok;

  // scanner
  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [AW-1:0]       r_ch_idx;
  logic [CHANNELS-1:0] r_sel;
  logic                r_sample;
  logic                r_busy;
  logic                r_chop;
  logic [DWELL_W-1:0]  w_dwell_len;
  logic [CHANNELS-1:0] w_onehot;
  logic                w_last_phase;

  // The incoming bit completes the frame view; address sits in the top AW bits.
  assign w_frame = {r_shift, bus.ser_data};
  assign w_addr  = w_frame[FRAME_W-1 -: AW];
  assign w_data  = w_frame[TRIM_W-1:0];

  // Every address decodes to a real channel when CHANNELS is a power of two.
  if (CHANNELS == (1 << AW)) begin : g_addr_full
    assign w_addr_ok = 1'b1;
  end else begin : g_addr_part
    assign w_addr_ok = (w_addr < AW'(CHANNELS));
  end

  // A zero dwell still gives one switched-on cycle.
  assign w_dwell_len = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  assign w_onehot    = CHANNELS'(1) << r_ch_idx;

  // The channel index advances only after the final DWELL phase of a channel.
`ifdef OPAMP_CHOP_EN
  assign w_last_phase = r_chop;
`else
  assign w_last_phase = 1'b1;
`endif

  // Shift in frame bits and commit the trim word on the last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      for (int i = 0; i < CHANNELS; i++) r_trim[i] <= '0;
    end else if (bus.ena) begin
      if (bus.ser_clr) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (bus.ser_valid) begin
        if (r_bit_cnt == BIT_LAST) begin
          r_bit_cnt <= '0;
          r_shift   <= '0;
          if (w_addr_ok) r_trim[w_addr] <= w_data;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_shift   <= w_frame[FRAME_W-2:0];
        end
      end
    end
  end

  // Scanner FSM: IDLE -> DEAD -> DWELL -> DEAD ...; run low returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ch_idx <= '0;
      r_sel    <= '0;
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_chop   <= 1'b0;
    end else if (bus.ena) begin
      if (!bus.run) begin
        r_state  <= S_IDLE;
        r_sel    <= '0;
        r_sample <= 1'b0;
        r_busy   <= 1'b0;
        r_chop   <= 1'b0;
      end else begin
        r_busy <= 1'b1;
        case (r_state)
          S_IDLE: begin
            r_state <= S_DEAD;
            r_cnt   <= DEAD_LAST;
          end
          S_DEAD: begin
            if (r_cnt == '0) begin
              r_state  <= S_DWELL;
              r_cnt    <= CNT_W'(w_dwell_len - 1'b1);
              r_sel    <= w_onehot;
              r_sample <= (w_dwell_len == DWELL_W'(1));
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_DWELL: begin
            if (r_cnt == '0) begin
              r_state  <= S_DEAD;
              r_cnt    <= DEAD_LAST;
              r_sel    <= '0;
              r_sample <= 1'b0;
              r_chop   <= ~w_last_phase;
              if (w_last_phase)
                r_ch_idx <= (r_ch_idx == CH_LAST) ? '0 : r_ch_idx + 1'b1;
            end else begin
              r_cnt    <= r_cnt - 1'b1;
              r_sample <= (r_cnt == CNT_W'(1));
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_sample <= 1'b0;
            r_busy   <= 1'b0;
            r_chop   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sel      = r_sel;
  assign bus.ch_idx   = r_ch_idx;
  assign bus.trim_out = r_trim[r_ch_idx];
  assign bus.sample   = r_sample & bus.ena;
  assign bus.chop     = r_chop;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_opamp_trim_sequencer.sv
// Randomized bench for opamp_trim_sequencer: a 4-channel and a 3-channel
// instance share stimulus and are compared every cycle against a timeline
// model (channel period arithmetic) and a trim-array model.
module tb_opamp_trim_sequencer;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  opamp_trim_sequencer_if #(.CHANNELS(4), .TRIM_W(5), .DWELL_W(8)) bus4 ();
  opamp_trim_sequencer_if #(.CHANNELS(3), .TRIM_W(5), .DWELL_W(8)) bus3 ();

  assign bus3.ena       = bus4.ena;
  assign bus3.ser_valid = bus4.ser_valid;
  assign bus3.ser_data  = bus4.ser_data;
  assign bus3.ser_clr   = bus4.ser_clr;
  assign bus3.run       = bus4.run;
  assign bus3.dwell     = bus4.dwell;

  opamp_trim_sequencer #(.CHANNELS(4), .TRIM_W(5), .DWELL_W(8), .DEAD_CYCLES(D))
    u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  opamp_trim_sequencer #(.CHANNELS(3), .TRIM_W(5), .DWELL_W(8), .DEAD_CYCLES(D))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  wire [13:0] act4 = {bus4.sel, bus4.ch_idx, bus4.sample, bus4.busy, bus4.chop, bus4.trim_out};
  wire [12:0] act3 = {bus3.sel, bus3.ch_idx, bus3.sample, bus3.busy, bus3.chop, bus3.trim_out};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  int trims4 [4];
  int trims3 [3];
  int ser_val, ser_cnt;
  bit scan_on;
  int t, c0_4, c0_3, held4, held3, dw;
  bit sq [$];
  logic [13:0] exp4;
  logic [12:0] exp3;

  task automatic push_frame(input int addr, input int data, input int nbits);
    int v;
    v = addr * 32 + data;
    for (int i = 6; i >= 7 - nbits; i--) sq.push_back(bit'((v >> i) & 1));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) trims4[i] = 0;
    for (int i = 0; i < 3; i++) trims3[i] = 0;
    ser_val = 0; ser_cnt = 0; scan_on = 0; t = 0;
    held4 = 0; held3 = 0; exp4 = '0; exp3 = '0;
  endtask

  // Drive one cycle, advance the model across the edge, compute expectations.
  task automatic step(input bit e, input bit r, input bit sc);
    bit b, v, smp, in_dw;
    int a, dat, p, k, rr, adv, ph;
    b = 1'b0; v = 1'b0;
    if (sq.size() > 0) begin b = sq.pop_front(); v = 1'b1; end
    bus4.ena = e; bus4.run = r; bus4.ser_clr = sc; bus4.ser_valid = v; bus4.ser_data = b;
    @(posedge clk); #1; cyc++;
    if (e) begin
      if (sc) begin
        ser_val = 0; ser_cnt = 0;
      end else if (v) begin
        ser_val = ser_val * 2 + int'(b);
        ser_cnt++;
        if (ser_cnt == 7) begin
          a = ser_val / 32; dat = ser_val % 32;
          trims4[a] = dat;
          if (a < 3) trims3[a] = dat;
          ser_val = 0; ser_cnt = 0;
        end
      end
      if (r) begin
        if (!scan_on) begin
          scan_on = 1; t = 0; c0_4 = held4; c0_3 = held3;
          dw = (bus4.dwell == 0) ? 1 : int'(bus4.dwell);
        end
        t++;
      end else begin
        scan_on = 0;
      end
    end
    if (scan_on) begin
      p = D + dw; k = (t - 1) / p; rr = (t - 1) % p;
`ifdef OPAMP_CHOP_EN
      adv = k / 2; ph = k % 2;
`else
      adv = k; ph = 0;
`endif
      held4 = (c0_4 + adv) % 4;
      held3 = (c0_3 + adv) % 3;
      in_dw = (rr >= D);
      smp = (rr == p - 1) && e;
      exp4 = {in_dw ? 4'(1 << held4) : 4'd0, 2'(held4), smp, 1'b1, ph[0], 5'(trims4[held4])};
      exp3 = {in_dw ? 3'(1 << held3) : 3'd0, 2'(held3), smp, 1'b1, ph[0], 5'(trims3[held3])};
    end else begin
      exp4 = {4'd0, 2'(held4), 3'b000, 5'(trims4[held4])};
      exp3 = {3'd0, 2'(held3), 3'b000, 5'(trims3[held3])};
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus4.ena = 1'b1; bus4.run = 1'b0; bus4.ser_valid = 1'b0; bus4.ser_clr = 1'b0;
    bus4.ser_data = 1'b0;
    sq.delete();
    @(posedge clk); #1; cyc++;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (act4 !== 14'd0) begin errors++; $display("FAIL reset4 got=%h exp=%h", act4, 14'd0); end
    checks++;
    if (act3 !== 13'd0) begin errors++; $display("FAIL reset3 got=%h exp=%h", act3, 13'd0); end
    rst_n = 1'b1;
    bus4.dwell = 8'd3;
    push_frame(0, 31, 7);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if (act4 !== exp4) begin errors++; $display("FAIL ena_low4 cyc=%0d got=%h exp=%h", cyc, act4, exp4); end
    end
    checks++;
    if (bus4.busy !== 1'b0 || bus4.trim_out !== 5'd0)
      begin errors++; $display("FAIL ena_low_state busy=%b trim=%0d exp busy=0 trim=0", bus4.busy, bus4.trim_out); end
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_serial();
    int d;
    push_frame(1, 22, 7);
    repeat (8) step(1'b1, 1'b0, 1'b0);
    checks++;
    if (u_dut4.r_trim[1] !== 5'd22) begin errors++; $display("FAIL frame_ch1 got=%0d exp=22", u_dut4.r_trim[1]); end
    d = $urandom_range(1, 31);
    push_frame(0, d, 7);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (act4 !== exp4) begin errors++; $display("FAIL frame_ch0 cyc=%0d got=%h exp=%h", cyc, act4, exp4); end
    end
    checks++;
    if (bus4.trim_out !== 5'(d)) begin errors++; $display("FAIL trim_ch0 got=%0d exp=%0d", bus4.trim_out, d); end
    // partial frame to address 3 discarded by ser_clr
    push_frame(3, 17, 3);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    push_frame(2, $urandom_range(0, 31), 7);
    repeat (7) step(1'b1, 1'b0, 1'b0);
    checks++;
    if (u_dut4.r_trim[3] !== 5'(trims4[3]) || u_dut4.r_trim[2] !== 5'(trims4[2]))
      begin errors++; $display("FAIL clr_frame t3=%0d t2=%0d exp t3=%0d t2=%0d", u_dut4.r_trim[3], u_dut4.r_trim[2], trims4[3], trims4[2]); end
    // ser_clr wins over a same-cycle ser_valid
    push_frame(1, 0, 1);
    step(1'b1, 1'b0, 1'b1);
    push_frame(0, $urandom_range(0, 31), 7);
    repeat (7) step(1'b1, 1'b0, 1'b0);
    checks++;
    if (act4 !== exp4) begin errors++; $display("FAIL clr_wins got=%h exp=%h", act4, exp4); end
    // address 3 is out of range for the 3-channel instance
    push_frame(3, $urandom_range(0, 31), 7);
    repeat (7) step(1'b1, 1'b0, 1'b0);
    checks++;
    if (u_dut4.r_trim[3] !== 5'(trims4[3])) begin errors++; $display("FAIL addr3_dut4 got=%0d exp=%0d", u_dut4.r_trim[3], trims4[3]); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (u_dut3.r_trim[i] !== 5'(trims3[i])) begin errors++; $display("FAIL oor_dut3 ch=%0d got=%0d exp=%0d", i, u_dut3.r_trim[i], trims3[i]); end
    end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 4; i++) push_frame(i, $urandom_range(0, 31), 7);
    repeat (28) step(1'b1, 1'b0, 1'b0);
    bus4.dwell = 8'd3;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (act4 !== exp4) begin errors++; $display("FAIL scan4 cyc=%0d got=%h exp=%h", cyc, act4, exp4); end
      checks++;
      if (act3 !== exp3) begin errors++; $display("FAIL scan3 cyc=%0d got=%h exp=%h", cyc, act3, exp3); end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (act4 !== exp4) begin errors++; $display("FAIL scan_stop cyc=%0d got=%h exp=%h", cyc, act4, exp4); end
    end
  endtask

  task automatic test_dwell0_stop_resume();
    bus4.dwell = 8'd0;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < int'($urandom_range(4, 20)); i++) begin
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (act4 !== exp4) begin errors++; $display("FAIL dwell0_4 cyc=%0d got=%h exp=%h", cyc, act4, exp4); end
        checks++;
        if (act3 !== exp3) begin errors++; $display("FAIL dwell0_3 cyc=%0d got=%h exp=%h", cyc, act3, exp3); end
      end
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (act4 !== exp4) begin errors++; $display("FAIL stop4 cyc=%0d got=%h exp=%h", cyc, act4, exp4); end
      end
    end
  endtask

  task automatic test_trim_write_during_dwell();
    bus4.dwell = 8'd10;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) push_frame(held4, (trims4[held4] + 1 + int'($urandom_range(0, 29))) % 32, 7);
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (act4 !== exp4) begin errors++; $display("FAIL trimwr4 cyc=%0d got=%h exp=%h", cyc, act4, exp4); end
      checks++;
      if (act3 !== exp3) begin errors++; $display("FAIL trimwr3 cyc=%0d got=%h exp=%h", cyc, act3, exp3); end
    end
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit r, e, sc;
    r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) r = ~r;
      if (!scan_on) bus4.dwell = 8'($urandom_range(0, 5));
      e  = ($urandom_range(0, 9) != 0);
      sc = ($urandom_range(0, 39) == 0);
      if (sq.size() == 0 && $urandom_range(0, 5) == 0)
        push_frame($urandom_range(0, 3), $urandom_range(0, 31), 7);
      step(e, r, sc);
      checks++;
      if (act4 !== exp4) begin errors++; $display("FAIL b2b4 cyc=%0d got=%h exp=%h", cyc, act4, exp4); end
      checks++;
      if (act3 !== exp3) begin errors++; $display("FAIL b2b3 cyc=%0d got=%h exp=%h", cyc, act3, exp3); end
    end
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midscan();
    bus4.dwell = 8'd2;
    for (int i = 0; i < 4; i++) push_frame(i, $urandom_range(1, 31), 7);
    repeat (12) step(1'b1, 1'b1, 1'b0);
    apply_reset();
    checks++;
    if (act4 !== 14'd0) begin errors++; $display("FAIL midreset4 got=%h exp=%h", act4, 14'd0); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (act4 !== exp4) begin errors++; $display("FAIL postreset4 cyc=%0d got=%h exp=%h", cyc, act4, exp4); end
    end
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus4.dwell = 8'd0;
    model_reset();
    test_reset();
    test_serial();
    test_scan();
    test_dwell0_stop_resume();
    test_trim_write_during_dwell();
    test_back_to_back();
    test_reset_midscan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
